// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the load/store sequencer: FSM states,
// request size encodings, byte counts and alignment checking.
package mem_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Number of byte accesses for a size code; 0 for the illegal code.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // True when the size is legal and the address is a multiple of it.
  function automatic logic size_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr_lo[0];
      SZ_WORD: return (addr_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ram.sv
// Byte-wide dual-port RAM: synchronous write, registered read.
// Read data appears in the cycle after r_en/add_r.
module ram #(
  parameter int AddressSize = 10,
  parameter int WordSize    = 8
) (
  input  logic                   clk,
  input  logic [AddressSize-1:0] add_w,
  input  logic [WordSize-1:0]    data_w,
  input  logic                   w_en,
  input  logic [AddressSize-1:0] add_r,
  input  logic                   r_en,
  output logic [WordSize-1:0]    data_r
);

  logic [WordSize-1:0] mem_q [0:(1<<AddressSize)-1];

  always_ff @(posedge clk) begin
    if (w_en) mem_q[add_w] <= data_w;
    if (r_en) data_r <= mem_q[add_r];
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store sequencer: splits 32-bit CPU requests into byte accesses on a
// dual-port RAM and returns little-endian, zero-extended load data.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int AddressSize = 10,
  parameter int WordSize    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic [AddressSize-1:0] req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_rdata,
  output logic                   resp_err,
  output logic [AddressSize-1:0] add_w,
  output logic [WordSize-1:0]    data_w,
  output logic                   w_en,
  output logic [AddressSize-1:0] add_r,
  output logic                   r_en,
  input  logic [WordSize-1:0]    data_r
);

  state_e                 state_q, state_d;
  logic [AddressSize-1:0] addr_q;
  logic [3:0][7:0]        wdata_q;
  logic [3:0][7:0]        acc_q;
  logic [2:0]             n_q, i_q;
  logic                   err_q;
  logic                   cap_vld_q;
  logic [1:0]             cap_idx_q;
  logic                   last_byte;
  logic                   req_ok;

  assign last_byte = (i_q == n_q - 3'd1);
  assign req_ok    = size_aligned(req_size, req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = !req_ok ? S_RESP : (req_we ? S_WRITE : S_READ);
      S_WRITE: if (last_byte) state_d = S_RESP;
      S_READ:  if (last_byte) state_d = S_DRAIN;
      S_DRAIN: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data lags its issue by one cycle, so the byte index travels with a
  // capture flag and lands in the accumulator a cycle later (DRAIN covers the last).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      acc_q     <= '0;
      n_q       <= '0;
      i_q       <= '0;
      err_q     <= 1'b0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      cap_vld_q <= (state_q == S_READ);
      cap_idx_q <= i_q[1:0];
      if (state_q == S_IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        n_q     <= size_bytes(req_size);
        err_q   <= !req_ok;
        i_q     <= '0;
        acc_q   <= '0;
      end else begin
        if (state_q == S_WRITE || state_q == S_READ) i_q <= i_q + 3'd1;
        if (cap_vld_q) acc_q[cap_idx_q] <= data_r;
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_err   = 1'b0;
    resp_rdata = '0;
    w_en       = 1'b0;
    r_en       = 1'b0;
    add_w      = '0;
    add_r      = '0;
    data_w     = '0;
    case (state_q)
      S_WRITE: begin
        w_en   = 1'b1;
        add_w  = addr_q + AddressSize'(i_q);
        data_w = wdata_q[i_q[1:0]];
      end
      S_READ: begin
        r_en  = 1'b1;
        add_r = addr_q + AddressSize'(i_q);
      end
      S_RESP: begin
        resp_err   = err_q;
        resp_rdata = acc_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed plus randomized bench for mem_lsu attached to ram; expectations
// come from a byte-array memory model and the cycle rules of each request.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_size;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  add_w, add_r;
  logic [7:0]  data_w, data_r;
  logic        w_en, r_en;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [0:1023];

  always #5 clk = ~clk;

  mem_lsu #(.AddressSize(10), .WordSize(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .add_w(add_w), .data_w(data_w), .w_en(w_en),
    .add_r(add_r), .r_en(r_en), .data_r(data_r)
  );

  ram #(.AddressSize(10), .WordSize(8)) u_ram (
    .clk(clk), .add_w(add_w), .data_w(data_w), .w_en(w_en),
    .add_r(add_r), .r_en(r_en), .data_r(data_r)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request; called at a negedge with the DUT idle, returns at a
  // negedge with the DUT idle again.
  task automatic run_req(input bit we, input bit [1:0] sz, input bit [9:0] addr,
                         input bit [31:0] wd, input int hold);
    int          n;
    bit          err;
    int          resp_cyc;
    logic [31:0] exp_rd;
    n        = 1 << sz;
    err      = (sz == 2'b11) || ((addr % n) != 0);
    resp_cyc = err ? 1 : (we ? n + 1 : n + 2);
    exp_rd   = '0;
    if (!err && !we)
      for (int k = 0; k < n; k++) exp_rd[8*k +: 8] = model[10'(addr + k)];

    chk("req_ready idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= resp_cyc; c++) begin
      bit wexp, rexp;
      wexp = !err && we && c <= n;
      rexp = !err && !we && c <= n;
      chk($sformatf("w_en c%0d", c), 32'(w_en), 32'(wexp));
      chk($sformatf("r_en c%0d", c), 32'(r_en), 32'(rexp));
      if (wexp) begin
        chk($sformatf("add_w c%0d", c), 32'(add_w), 32'(10'(addr + c - 1)));
        chk($sformatf("data_w c%0d", c), 32'(data_w), 32'(wd[8*(c-1) +: 8]));
      end
      if (rexp) chk($sformatf("add_r c%0d", c), 32'(add_r), 32'(10'(addr + c - 1)));
      chk($sformatf("resp_valid c%0d", c), 32'(resp_valid), 32'(c == resp_cyc));
      if (c != resp_cyc) @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      chk("resp_err", 32'(resp_err), 32'(err));
      chk("resp_rdata", resp_rdata, exp_rd);
      if (h > 0) begin
        chk("resp_valid hold", 32'(resp_valid), 32'd1);
        chk("req_ready hold", 32'(req_ready), 32'd0);
      end
      if (h < hold) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_valid after hs", 32'(resp_valid), 32'd0);
    chk("req_ready after hs", 32'(req_ready), 32'd1);
    if (!err && we)
      for (int k = 0; k < n; k++) model[10'(addr + k)] = wd[8*k +: 8];
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst w_en", 32'(w_en), 32'd0);
    chk("rst r_en", 32'(r_en), 32'd0);
    chk("rst add_w", 32'(add_w), 32'd0);
    chk("rst add_r", 32'(add_r), 32'd0);
    chk("rst data_w", 32'(data_w), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the low 256 bytes so every later load reads defined data.
    for (int a = 0; a < 256; a += 4) run_req(1'b1, 2'b10, 10'(a), $urandom, 0);

    run_req(1'b1, 2'b10, 10'h010, 32'hDEADBEEF, 0);
    run_req(1'b0, 2'b10, 10'h010, 32'h0, 0);
    run_req(1'b1, 2'b00, 10'h3FE, 32'h00, 0);
    run_req(1'b1, 2'b00, 10'h3FF, 32'h5A, 0);
    run_req(1'b0, 2'b01, 10'h3FE, 32'h0, 0);
    chk("half load top", {16'h0, model[10'h3FF], model[10'h3FE]}, 32'h00005A00);
    run_req(1'b0, 2'b10, 10'h012, 32'h0, 0);
    run_req(1'b0, 2'b11, 10'h000, 32'h0, 0);
    run_req(1'b0, 2'b10, 10'h010, 32'h0, 3);
    run_req(1'b0, 2'b00, 10'h013, 32'h0, 0);

    // Reset during the second write byte of a word store.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 10'h020;
    req_wdata = 32'h11223344;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst-mid w_en c1", 32'(w_en), 32'd1);
    @(negedge clk);
    chk("rst-mid w_en c2", 32'(w_en), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst-mid w_en", 32'(w_en), 32'd0);
    chk("rst-mid req_ready", 32'(req_ready), 32'd1);
    chk("rst-mid resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst-mid no resp", 32'(resp_valid), 32'd0);
    model[10'h020] = 8'h44;
    model[10'h021] = 8'h33;
    run_req(1'b0, 2'b10, 10'h020, 32'h0, 0);

    for (int t = 0; t < 80; t++) begin
      bit       we;
      bit [1:0] sz;
      bit [9:0] a;
      we = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 10'($urandom_range(0, 252));
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~10'((1 << sz) - 1);
      run_req(we, sz, a, $urandom, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store sequencer between the CPU datapath and the byte-wide dual-port `ram`. It accepts one 32-bit load or store request per transaction over a valid/ready handshake. Each request is split into 1, 2 or 4 sequential byte accesses on the RAM's write or read port. The loaded word is assembled little-endian and returned on a held response channel. It is the only master of both RAM ports.

## Interface
- `AddressSize`, 10, RAM byte-address width; must match the attached `ram`.
- `WordSize`, 8, RAM word width; fixed at 8 for this block.
- `clk` input 1, single clock; all state changes on the rising edge.
- `rst_n` input 1, reset, synchronous and active-low.
- `req_valid` input 1, request present.
- `req_ready` output 1, block can accept a request.
- `req_we` input 1, 1 = store, 0 = load.
- `req_size` input 2, 00 byte, 01 half, 10 word, 11 illegal.
- `req_addr` input AddressSize, byte address.
- `req_wdata` input 32, store data; low bytes used for byte and half stores.
- `resp_valid` output 1, response present.
- `resp_ready` input 1, CPU accepts the response.
- `resp_rdata` output 32, load data, zero-extended; 0 for stores and errors.
- `resp_err` output 1, request was misaligned or illegal; no RAM access was made.
- `add_w` output AddressSize, RAM write address.
- `data_w` output 8, RAM write data.
- `w_en` output 1, RAM write strobe.
- `add_r` output AddressSize, RAM read address.
- `r_en` output 1, RAM read strobe.
- `data_r` input 8, RAM read data; valid in the cycle after `r_en`/`add_r`.

## Operation
- States: IDLE, WRITE, READ, DRAIN, RESP.
- IDLE: `req_ready`=1. A handshake (`req_valid`&&`req_ready` at an edge) latches `req_we`, `req_size`, `req_addr` and `req_wdata`. It also loads `n` = 1<<size and clears byte index `i` and the data accumulator.
  - Illegal size, or `req_addr` not a multiple of `n`: go to RESP with `resp_err`=1.
  - Otherwise a store goes to WRITE and a load goes to READ.
- WRITE: `w_en`=1, `add_w`=base+i, `data_w`=wdata[8i+7:8i]. `i` increments each cycle. After byte n-1, go to RESP.
- READ: `r_en`=1, `add_r`=base+i, `i` increments. Byte j of `data_r`, returned one cycle after issue j, is written into accumulator bits [8j+7:8j]. After issue n-1, go to DRAIN.
- DRAIN: no strobes. Capture the last byte, then go to RESP.
- RESP: `resp_valid`=1 with `resp_rdata` and `resp_err` stable. Hold until `resp_ready`, then go to IDLE. `req_ready`=0 here, so requests never overlap.
- Address arithmetic is modulo 2^AddressSize. An aligned access never crosses the top of memory, so it never wraps.
- `w_en` and `r_en` are never high in the same cycle.
- Unused accumulator bytes stay 0, which gives zero-extension.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from request inputs to RAM outputs.
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `w_en`=0, `r_en`=0, `add_w`=0, `add_r`=0, `data_w`=0; state IDLE.
- Cycle numbering: accept edge = cycle 0.
  - Store: `w_en` high in cycles 1..n; `resp_valid` from cycle n+1.
  - Load: `r_en` high in cycles 1..n; last byte captured at the end of cycle n+1; `resp_valid` from cycle n+2.
  - Error: `resp_valid` from cycle 1.
- If `resp_ready` is already high, the response lasts one cycle. The next request can be accepted in the cycle after the response handshake.
- Reset in mid-operation takes effect at the next edge: strobes drop and state goes to IDLE. Bytes already written stay in RAM, and no response is produced.
- `req_valid` may be held across RESP; it is accepted only in IDLE.

## Structure
- `mem_lsu_pkg`:
  - state enum;
  - size encodings `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`;
  - function returning byte count from size;
  - function checking alignment.
- No sub-module. The 32-bit byte-lane select and accumulator are inline.
- The testbench instantiates `mem_lsu` together with `ram`.

## Test plan
- Reset, then word store of 0xDEADBEEF at address 0x010 → `w_en` in cycles 1–4 writing 0xEF, 0xBE, 0xAD, 0xDE to 0x010–0x013; `resp_valid` in cycle 5 with `resp_err`=0.
- Word load from 0x010 → `r_en` in cycles 1–4; `resp_rdata`=0xDEADBEEF in cycle 6.
- Byte store 0x5A to 0x3FF, then half load from 0x3FE → `resp_rdata`=0x00005A00 (assuming 0x3FE holds 0x00); no address wrap.
- Word load from 0x012 → `resp_err`=1 and `resp_rdata`=0 in cycle 1, with no `r_en` or `w_en`. Size 11 at 0x000 → the same error response.
- Hold `resp_ready`=0 for 3 cycles after a load → `resp_valid` and data stay stable and `req_ready` stays 0. Release → the next request is accepted in the following cycle.
- Assert `rst_n`=0 in cycle 2 of a word store → `w_en`=0 after that edge, state IDLE, `req_ready`=1, no response. Bytes 0–1 are present in RAM.
